dt_inverse_search: RTL and testbench
====================================

// Module: dt_inverse_search
// PURPOSE
//   Inverse map for a combinational decision-tree classifier. For a requested class code, the block
//   drives every IN_W-bit candidate input into an external classifier instance, from 0 up to 2^IN_W-1.
//   Each candidate whose class equals the target is streamed out on a valid/ready port.
//   It sits beside one classifier instance and supports coverage, debug and class-preimage queries.
// PARAMETERS
//   IN_W   8  classifier input width; the candidate space is 2^IN_W
//   OUT_W  8  classifier output (class code) width
// PORTS
//   clk          in   1        single clock; all state updates on its rising edge
//   rst          in   1        asynchronous, active-high reset
//   start_i      in   1        request a search; accepted only in IDLE
//   target_i     in   OUT_W    class code to invert; sampled on the cycle start is accepted
//   abort_i      in   1        cancel the search in progress
//   cand_o       out  IN_W     candidate input, wired to the classifier's input
//   cand_class_i in   OUT_W    classifier output for cand_o; combinational, same cycle
//   hit_valid_o  out  1        a matching candidate is presented on hit_data_o
//   hit_data_o   out  IN_W     the matching candidate
//   hit_ready_i  in   1        consumer accepts the hit
//   busy_o       out  1        high in SCAN, EMIT and DONE
//   done_o       out  1        one-cycle pulse when the search completes
//   count_o      out  IN_W+1   number of hits in the last completed search
//   found_o      out  1        count_o != 0
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; the target register is 0.
//   IDLE:
//     - start_i=1 latches target_i, clears cand_o and the hit counter, then goes to SCAN.
//     - count_o and found_o are not cleared here; they keep the last completed result until DONE.
//   SCAN:
//     - If cand_class_i == target: hit_data_o<=cand_o, hit_valid_o<=1, counter++, go to EMIT.
//       cand_o holds its value.
//     - Otherwise, if cand_o == 2^IN_W-1 go to DONE, else cand_o++.
//   EMIT:
//     - hit_valid_o and hit_data_o stay stable until hit_valid_o && hit_ready_i.
//     - On that handshake: hit_valid_o<=0; if cand_o == max go to DONE, else cand_o++ and go to SCAN.
//     - Backpressure may last any number of cycles; the scan stalls and no hit is dropped.
//   DONE: done_o=1 for exactly one cycle; count_o and found_o update at the same edge; next IDLE.
//   Latency, with start accepted in cycle 0 and hit_ready_i held high:
//     - first SCAN is in cycle 1;
//     - each non-hit candidate costs 1 cycle, each hit costs 2 cycles;
//     - done_o is high in cycle 1 + 2^IN_W + H, where H is the number of hits.
//   Wrap-around:
//     - cand_o never wraps; a hit on the last candidate is emitted and then the block goes to DONE.
//     - count_o can reach 2^IN_W, hence its width IN_W+1.
//   Simultaneous events:
//     - abort_i has priority over start_i, handshake and match.
//     - start_i while busy_o=1 is ignored.
//   abort_i in SCAN, EMIT or DONE:
//     - next state is IDLE; hit_valid_o<=0, cand_o<=0;
//     - no done_o pulse is issued and count_o and found_o keep their old values.
//   Async reset mid-search returns immediately to the reset values above.
// STRUCTURE
//   Package dt_pkg:
//     - DT_IN_W and DT_OUT_W defaults;
//     - typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} dt_srch_state_t.
//   Single module, no sub-modules. The classifier is instantiated by the parent, not inside this block.
// TESTING
//   Bench classifier stub: cand_class_i = cand_o & 8'h0F.
//   1. target=8'h05, ready=1 -> 16 hits 0x05,0x15,..,0xF5 in order; done_o in cycle 273;
//      count_o=16; found_o=1.
//   2. target=8'h80 -> no hits; done_o in cycle 257; count_o=0; found_o=0.
//   3. Stub replaced by cand_o^8'hA5, target=8'h5A -> single hit 0xFF, the last candidate, emitted;
//      then DONE; count_o=1.
//   4. Scenario 1 with hit_ready_i randomly low 50% of cycles -> same 16 hits in order;
//      hit_data_o stable while stalled; count_o=16.
//   5. abort_i asserted while EMIT holds 0x25 -> IDLE next cycle, hit_valid_o=0, no done_o,
//      count_o unchanged; a new start then succeeds.
//   6. start_i pulsed during SCAN with a different target -> ignored; results match the original
//      target. Reset asserted mid-SCAN -> all outputs 0 immediately.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared widths and state encoding for the decision-tree inverse search.
package dt_pkg;

  localparam int DT_IN_W  = 8;
  localparam int DT_OUT_W = 8;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} dt_srch_state_t;

endpackage

// File: rtl/dt_inverse_search.sv
// Sweeps every classifier input from 0 to max and streams out each candidate
// whose class matches the latched target; reports hit count on completion.
module dt_inverse_search
  import dt_pkg::*;
#(
  parameter int IN_W  = DT_IN_W,
  parameter int OUT_W = DT_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [OUT_W-1:0] target_i,
  input  logic             abort_i,
  output logic [IN_W-1:0]  cand_o,
  input  logic [OUT_W-1:0] cand_class_i,
  output logic             hit_valid_o,
  output logic [IN_W-1:0]  hit_data_o,
  input  logic             hit_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [IN_W:0]    count_o,
  output logic             found_o
);

  dt_srch_state_t   state;
  logic [OUT_W-1:0] target;
  logic [IN_W:0]    hits;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      target      <= '0;
      hits        <= '0;
      cand_o      <= '0;
      hit_valid_o <= 1'b0;
      hit_data_o  <= '0;
      done_o      <= 1'b0;
      count_o     <= '0;
      found_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      // abort outranks start, match and handshake; results stay untouched
      if (abort_i && state != IDLE) begin
        state       <= IDLE;
        hit_valid_o <= 1'b0;
        cand_o      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              target <= target_i;
              cand_o <= '0;
              hits   <= '0;
              state  <= SCAN;
            end
          end
          SCAN: begin
            if (cand_class_i == target) begin
              hit_data_o  <= cand_o;
              hit_valid_o <= 1'b1;
              hits        <= hits + (IN_W+1)'(1);
              state       <= EMIT;
            end else if (&cand_o) begin
              state   <= DONE;
              done_o  <= 1'b1;
              count_o <= hits;
              found_o <= (hits != '0);
            end else begin
              cand_o <= cand_o + IN_W'(1);
            end
          end
          EMIT: begin
            if (hit_ready_i) begin
              hit_valid_o <= 1'b0;
              if (&cand_o) begin
                state   <= DONE;
                done_o  <= 1'b1;
                count_o <= hits;
                found_o <= (hits != '0);
              end else begin
                cand_o <= cand_o + IN_W'(1);
                state  <= SCAN;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dt_inverse_search.sv
// Directed bench for dt_inverse_search with a masking / XOR classifier stub.
module tb_dt_inverse_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] target = '0;
  logic       abort = 1'b0;
  logic [7:0] cand;
  logic [7:0] cand_class;
  logic       hit_valid;
  logic [7:0] hit_data;
  logic       hit_ready = 1'b1;
  logic       busy;
  logic       done;
  logic [8:0] count;
  logic       found;
  logic       xor_mode = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] hits [0:255];
  int nh;
  int dcyc;

  always #5 clk = ~clk;

  always_comb cand_class = xor_mode ? (cand ^ 8'hA5) : (cand & 8'h0F);

  dt_inverse_search #(.IN_W(8), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .target_i(target), .abort_i(abort),
    .cand_o(cand), .cand_class_i(cand_class), .hit_valid_o(hit_valid),
    .hit_data_o(hit_data), .hit_ready_i(hit_ready), .busy_o(busy),
    .done_o(done), .count_o(count), .found_o(found)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_search(input logic [7:0] tgt);
    @(negedge clk);
    start  = 1'b1;
    target = tgt;
    @(posedge clk);
    #1 start = 1'b0;
    target = 8'h00;
  endtask

  // Runs from cycle 1 until done_o; optional random backpressure and stray start pulse.
  task automatic run_to_done(input bit rnd, input int pulse_cyc, input logic [7:0] pulse_tgt);
    bit stalled = 0;
    logic [7:0] held = '0;
    nh = 0;
    dcyc = -1;
    for (int c = 1; c <= 2000 && dcyc < 0; c++) begin
      @(negedge clk);
      hit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == pulse_cyc) begin
        start  = 1'b1;
        target = pulse_tgt;
      end
      if (stalled) chk("stall_hold", {hit_valid, hit_data}, {1'b1, held});
      if (hit_valid) begin
        if (hit_ready && nh < 256) begin
          hits[nh] = hit_data;
          nh++;
        end
        stalled = !hit_ready;
        held    = hit_data;
      end else begin
        stalled = 0;
      end
      if (done) dcyc = c;
      @(posedge clk);
      #1 start = 1'b0;
    end
    hit_ready = 1'b1;
    if (dcyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_mask_hits(input string tag, input logic [7:0] lo);
    chk({tag, "_nhits"}, nh, 16);
    for (int i = 0; i < 16 && i < nh; i++)
      chk({tag, "_hit"}, hits[i], {4'(i), lo[3:0]});
  endtask

  task automatic check_after_done(input string tag);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {done, busy}, 2'b00);
  endtask

  initial begin
    // reset values
    #1;
    chk("rst_outs", {busy, done, hit_valid, found}, 4'b0000);
    chk("rst_vals", {count, cand, hit_data}, 25'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: mask stub, target 05, ready high
    start_search(8'h05);
    @(negedge clk);
    chk("s1_first_scan", {busy, cand}, {1'b1, 8'h00});
    run_to_done(0, 0, 8'h00);
    // first iteration already consumed one negedge above
    chk("s1_done_cyc", dcyc + 1, 273);
    check_mask_hits("s1", 8'h05);
    chk("s1_count", count, 16);
    chk("s1_found", found, 1);
    check_after_done("s1");

    // 2: no class 80 under the mask stub
    start_search(8'h80);
    run_to_done(0, 0, 8'h00);
    chk("s2_done_cyc", dcyc, 257);
    chk("s2_nhits", nh, 0);
    chk("s2_count", count, 0);
    chk("s2_found", found, 0);

    // 3: XOR stub, only candidate FF maps to 5A
    xor_mode = 1'b1;
    start_search(8'h5A);
    run_to_done(0, 0, 8'h00);
    chk("s3_done_cyc", dcyc, 258);
    chk("s3_nhits", nh, 1);
    chk("s3_hit", hits[0], 8'hFF);
    chk("s3_count", count, 1);
    chk("s3_found", found, 1);
    check_after_done("s3");
    xor_mode = 1'b0;

    // 4: random backpressure
    start_search(8'h05);
    run_to_done(1, 0, 8'h00);
    check_mask_hits("s4", 8'h05);
    chk("s4_count", count, 16);

    // 5: abort while 25 is held in EMIT
    start_search(8'h05);
    begin
      bit seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        hit_ready = !(hit_valid && hit_data == 8'h25);
        seen = hit_valid && hit_data == 8'h25;
        if (!seen) @(posedge clk);
      end
      chk("s5_reached_25", seen, 1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      hit_ready = 1'b1;
      chk("s5_abort", {busy, hit_valid, done, cand}, 11'h0);
      chk("s5_count_kept", {found, count}, {1'b1, 9'd16});
      @(negedge clk);
      chk("s5_no_done", {done, busy}, 2'b00);
    end
    start_search(8'h0C);
    run_to_done(0, 0, 8'h00);
    chk("s5_restart_cyc", dcyc, 273);
    check_mask_hits("s5", 8'h0C);

    // 6: stray start during SCAN is ignored, then async reset mid-scan
    start_search(8'h05);
    run_to_done(0, 10, 8'h07);
    check_mask_hits("s6", 8'h05);
    chk("s6_count", count, 16);
    start_search(8'h03);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("s6_pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("s6_rst_outs", {busy, done, hit_valid, found}, 4'b0000);
    chk("s6_rst_vals", {count, cand, hit_data}, 25'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
